// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: word geometry, reset vector and small helpers
// used by the Avalon slave memory and its wait-state controller.
package cpu_bus_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  // CPU fetches its first instruction here; it aliases onto word 0 of the RAM.
  localparam logic [WORD_W-1:0] RESET_VECTOR = 32'hBFC0_0000;

  // Byte address -> word index; callers truncate to the depth they decode.
  function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] addr);
    return addr >> 2;
  endfunction

  // Replace the byte lanes selected by be with the matching lanes of new_word.
  function automatic logic [WORD_W-1:0] merge_bytes(input logic [WORD_W-1:0] old_word,
                                                    input logic [WORD_W-1:0] new_word,
                                                    input logic [BE_W-1:0]   be);
    logic [WORD_W-1:0] res;
    res = old_word;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/avalon_wait_ctrl.sv
// Wait-state generator for an Avalon slave: holds waitrequest high for
// WAIT_CYCLES cycles at the start of each access, then releases it for the
// single cycle in which the transfer completes.
module avalon_wait_ctrl #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic read,
  input  logic write,
  output logic waitrequest
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES);

  logic             active;
  logic [CNT_W-1:0] cnt;

  assign active = read | write;

  // Count stall cycles of the current access; reload after the completing cycle.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process evaluation order.
    if (rst) begin
      cnt <= '0;
    end else if (!active || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Stall must be visible in the very first cycle of an access, so it is
  // decoded from the counter rather than registered.
  assign waitrequest = (WAIT_CYCLES == 0) ? 1'b0 : (active && cnt != LAST);

endmodule

// File: rtl/avalon_word_ram.sv
// Unified instruction/data word RAM on the CPU's Avalon bus, with a
// transparent side-band preload port used by test harnesses to deposit
// program words before the CPU runs.
//
// Storage is split into a clocked array (mem_q) and a per-word preload latch
// (pre_word). A toggle pair (pre_tag latched, ack_q clocked) marks words that
// were preloaded since the last clock edge; such words read from the latch
// until the next edge folds them back into mem_q. This keeps each storage
// element single-driven while letting preload act without a clock.
module avalon_word_ram
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              RAM_Reset,
  input  logic [WORD_W-1:0] address,
  input  logic              write,
  input  logic              read,
  output logic              waitrequest,
  input  logic [WORD_W-1:0] writedata,
  input  logic [BE_W-1:0]   byteenable,
  output logic [WORD_W-1:0] readdata,
  input  logic [WORD_W-1:0] instruction,
  input  logic              inst_input,
  input  logic [7:0]        inst_addr
);

  localparam int IDX_W = ADDR_BITS - 2;
  localparam int DEPTH = 2 ** IDX_W;

  logic [IDX_W-1:0]  bus_idx;
  logic [IDX_W-1:0]  pre_idx;
  logic              wr_go;

  logic [WORD_W-1:0] mem_q    [DEPTH];
  logic [WORD_W-1:0] pre_word [DEPTH];
  logic [WORD_W-1:0] eff      [DEPTH];
  logic [DEPTH-1:0]  pre_en;
  logic [DEPTH-1:0]  pre_tag;
  logic [DEPTH-1:0]  ack_q;
  logic [DEPTH-1:0]  pre_sel;

  // Upper address bits fall away here, so the reset vector aliases to word 0.
  assign bus_idx = IDX_W'(word_index(address));
  assign pre_idx = IDX_W'(word_index({24'd0, inst_addr}));

  avalon_wait_ctrl #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_ctrl (
    .clk         (clk),
    .rst         (RAM_Reset),
    .read        (read),
    .write       (write),
    .waitrequest (waitrequest)
  );

  // A reset cycle aborts any pending bus write.
  assign wr_go = write && !waitrequest && !RAM_Reset;

  // Decode which word the preload port is currently addressing.
  always_comb begin
    pre_en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pre_en[i] = inst_input && !RAM_Reset && (pre_idx == IDX_W'(i));
    end
  end

  // Preload backdoor: transparent while enabled, holds otherwise.
  always_latch begin
    // NOTE: this block is meant to be a latch; the missing else branches are
    // deliberate, unlike in always_comb where they would be a bug.
    for (int i = 0; i < DEPTH; i++) begin
      if (pre_en[i]) begin
        pre_word[i] <= instruction;
        pre_tag[i]  <= ~ack_q[i];
      end
    end
  end

  assign pre_sel = pre_tag ^ ack_q;

  // Current architectural contents: a fresh preload overrides the clocked copy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      eff[i] = pre_sel[i] ? pre_word[i] : mem_q[i];
    end
  end

  // Clocked storage: reset clear, preload, byte-lane bus write, else absorb
  // any pending preload so the latch copy can be released.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      ack_q[i] <= pre_tag[i];
      // NOTE: the whole array is cleared on reset because unwritten words must
      // read as zero (a MIPS nop); ordinary RAMs would leave contents alone.
      if (RAM_Reset) begin
        mem_q[i] <= '0;
      end else if (pre_en[i]) begin
        mem_q[i] <= instruction;
      end else if (wr_go && bus_idx == IDX_W'(i)) begin
        mem_q[i] <= merge_bytes(eff[i], writedata, byteenable);
      end else begin
        mem_q[i] <= eff[i];
      end
    end
  end

  // Combinational read; returns the pre-write word when read and write collide.
  always_comb begin
    readdata = '0;
    if (read && !waitrequest) readdata = eff[bus_idx];
  end

endmodule

// File: tb/tb_avalon_word_ram.sv
// Directed bench for avalon_word_ram: a zero-wait instance for preload and
// bus-function vectors, and a WAIT_CYCLES=2 instance for the stall sequence.
module tb_avalon_word_ram;
  import cpu_bus_pkg::*;

  logic        clk;
  logic        ram_reset;
  logic [31:0] instruction;
  logic        inst_input;
  logic [7:0]  inst_addr;

  logic [31:0] address0, writedata0, readdata0;
  logic        write0, read0, waitrequest0;
  logic [3:0]  byteenable0;

  logic [31:0] address2, writedata2, readdata2;
  logic        write2, read2, waitrequest2;
  logic [3:0]  byteenable2;

  int n_checks;
  int n_pass;

  avalon_word_ram #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut0 (
    .clk         (clk),
    .RAM_Reset   (ram_reset),
    .address     (address0),
    .write       (write0),
    .read        (read0),
    .waitrequest (waitrequest0),
    .writedata   (writedata0),
    .byteenable  (byteenable0),
    .readdata    (readdata0),
    .instruction (instruction),
    .inst_input  (inst_input),
    .inst_addr   (inst_addr)
  );

  avalon_word_ram #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut2 (
    .clk         (clk),
    .RAM_Reset   (ram_reset),
    .address     (address2),
    .write       (write2),
    .read        (read2),
    .waitrequest (waitrequest2),
    .writedata   (writedata2),
    .byteenable  (byteenable2),
    .readdata    (readdata2),
    .instruction (instruction),
    .inst_input  (inst_input),
    .inst_addr   (inst_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write0(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    address0    = addr;
    writedata0  = data;
    byteenable0 = be;
    write0      = 1'b1;
    @(negedge clk);
    write0      = 1'b0;
  endtask

  task automatic read0_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    address0 = addr;
    read0    = 1'b1;
    #1;
    check(tag, readdata0, exp);
    read0    = 1'b0;
  endtask

  // Sample waitrequest (and optionally readdata) of dut2 one step after a falling edge.
  task automatic ws_step(input string tag, input logic exp_wait);
    @(negedge clk);
    #1;
    check(tag, 32'(waitrequest2), 32'(exp_wait));
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    ram_reset   = 1'b1;
    instruction = '0;
    inst_input  = 1'b0;
    inst_addr   = '0;
    address0 = '0; writedata0 = '0; byteenable0 = '0; write0 = 1'b0; read0 = 1'b0;
    address2 = '0; writedata2 = '0; byteenable2 = '0; write2 = 1'b0; read2 = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    ram_reset = 1'b0;
    #1;
    check("rst_wait0", 32'(waitrequest0), 32'd0);
    check("rst_wait2", 32'(waitrequest2), 32'd0);
    check("rst_rdata", readdata0, 32'h0);

    // Preload word 1, then a one-cycle reset must clear it
    @(negedge clk);
    inst_addr   = 8'h04;
    instruction = 32'hDEAD_BEEF;
    inst_input  = 1'b1;
    #1;
    inst_input  = 1'b0;
    read0_check("pre_word1", 32'h04, 32'hDEAD_BEEF);
    @(negedge clk);
    ram_reset = 1'b1;
    @(negedge clk);
    ram_reset = 1'b0;
    read0_check("rst_clear", 32'h04, 32'h0);

    // Preload the three-word program at 1 ns spacing, no clock edge in between
    @(negedge clk);
    inst_input  = 1'b1;
    inst_addr   = 8'h04; instruction = 32'h2402_A234;
    #1;
    inst_addr   = 8'h08; instruction = 32'h0002_1202;
    #1;
    inst_addr   = 8'h0C; instruction = 32'h0000_0008;
    #1;
    inst_input  = 1'b0;
    #1;
    address0 = RESET_VECTOR + 32'h4;
    read0    = 1'b1;
    #0.5;
    check("pre_immediate", readdata0, 32'h2402_A234);
    read0    = 1'b0;
    read0_check("prog_w1", RESET_VECTOR + 32'h4, 32'h2402_A234);
    read0_check("prog_w2", RESET_VECTOR + 32'h8, 32'h0002_1202);
    read0_check("prog_w3", RESET_VECTOR + 32'hC, 32'h0000_0008);
    read0_check("prog_w0", RESET_VECTOR,         32'h0);
    @(negedge clk);
    address0 = RESET_VECTOR + 32'h4;
    #1;
    check("rd_idle_zero", readdata0, 32'h0);

    // Byte-enable write
    bus_write0(32'h10, 32'hFFFF_FFFF, 4'b1111);
    bus_write0(32'h10, 32'h1234_5678, 4'b0101);
    read0_check("byte_en", 32'h10, 32'hFF34_FF78);

    // Read/write collision returns the pre-write word
    bus_write0(32'h20, 32'hAAAA_5555, 4'b1111);
    @(negedge clk);
    address0    = 32'h20;
    writedata0  = 32'h1111_1111;
    byteenable0 = 4'b1111;
    write0      = 1'b1;
    read0       = 1'b1;
    #1;
    check("collide_old", readdata0, 32'hAAAA_5555);
    @(negedge clk);
    write0 = 1'b0;
    #1;
    check("collide_new", readdata0, 32'h1111_1111);
    read0 = 1'b0;

    // Preload wins over a bus write to the same word in the same cycle
    @(negedge clk);
    address0    = 32'h30;
    writedata0  = 32'h1212_1212;
    byteenable0 = 4'b1111;
    write0      = 1'b1;
    inst_addr   = 8'h30;
    instruction = 32'hCAFE_F00D;
    inst_input  = 1'b1;
    @(negedge clk);
    write0     = 1'b0;
    inst_input = 1'b0;
    read0_check("pre_priority", 32'h30, 32'hCAFE_F00D);

    // Wait states on a read: 1,1,0 with data in the third cycle
    @(negedge clk);
    address2 = RESET_VECTOR + 32'h8;
    read2    = 1'b1;
    #1;
    check("ws_rd_c1", 32'(waitrequest2), 32'd1);
    check("ws_rd_hold", readdata2, 32'h0);
    ws_step("ws_rd_c2", 1'b1);
    ws_step("ws_rd_c3", 1'b0);
    check("ws_rd_data", readdata2, 32'h0002_1202);
    @(negedge clk);
    read2 = 1'b0;
    #1;
    check("ws_idle", 32'(waitrequest2), 32'd0);

    // Wait states on a write: commits only on the third edge
    @(negedge clk);
    address2    = 32'h40;
    writedata2  = 32'h7777_7777;
    byteenable2 = 4'b1111;
    write2      = 1'b1;
    read2       = 1'b1;
    #1;
    check("ws_wr_c1", 32'(waitrequest2), 32'd1);
    ws_step("ws_wr_c2", 1'b1);
    ws_step("ws_wr_c3", 1'b0);
    check("ws_wr_pre", readdata2, 32'h0);
    @(negedge clk);
    write2 = 1'b0;
    #1;
    check("ws_rd2_c1", 32'(waitrequest2), 32'd1);
    ws_step("ws_rd2_c2", 1'b1);
    ws_step("ws_rd2_c3", 1'b0);
    check("ws_wr_post", readdata2, 32'h7777_7777);
    @(negedge clk);
    read2 = 1'b0;

    // Dropping the strobe mid-wait restarts the count
    @(negedge clk);
    read2 = 1'b1;
    #1;
    check("ws_drop_c0", 32'(waitrequest2), 32'd1);
    @(negedge clk);
    read2 = 1'b0;
    @(negedge clk);
    read2 = 1'b1;
    #1;
    check("ws_drop_c1", 32'(waitrequest2), 32'd1);
    ws_step("ws_drop_c2", 1'b1);
    ws_step("ws_drop_c3", 1'b0);
    check("ws_drop_data", readdata2, 32'h7777_7777);
    @(negedge clk);
    read2 = 1'b0;

    // Preload is ignored during reset, and reset clears everything
    @(negedge clk);
    ram_reset   = 1'b1;
    inst_addr   = 8'h04;
    instruction = 32'h0000_0055;
    inst_input  = 1'b1;
    @(negedge clk);
    inst_input = 1'b0;
    #1;
    ram_reset  = 1'b0;
    read0_check("rst_pre_ign", 32'h04, 32'h0);
    read0_check("rst_all", 32'h10, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
